// File: rtl/activation_unit.sv
// activation_unit: bias add, activation (identity / ReLU / leaky ReLU),
// round-half-up requantization with saturation, and a small output FIFO
// with valid/ready towards the next layer.
module activation_unit #(
  parameter int WIDTH      = 8,
  parameter int SHIFT      = 2,
  parameter int LEAK_SHIFT = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [2*WIDTH:0]       in_result,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [2*WIDTH:0]       bias,
  input  logic [1:0]                    mode,
  input  logic                          clear_sat,
  output logic signed [WIDTH-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sat_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int RW = 2*WIDTH + 1;         // neuron result width
  localparam int SW = RW + 1;              // bias sum width, cannot overflow
  localparam int QW = SW + 1;              // room for the rounding constant
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [QW-1:0] RND  = QW'((1 << SHIFT) >> 1);
  localparam logic signed [QW-1:0] QMAX = QW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [QW-1:0] QMIN = QW'(-(1 << (WIDTH-1)));

  logic                   accept;
  logic signed [SW-1:0]   s1_sum_reg;
  logic [1:0]             s1_mode_reg;
  logic                   s1_valid_reg;

  logic signed [SW-1:0]   act;
  logic signed [QW-1:0]   q_biased;
  logic signed [QW-1:0]   q_shifted;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [WIDTH-1:0]       q_out;

  logic [WIDTH-1:0]       mem_reg [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic [CW-1:0]          count_next;
  logic                   push;
  logic                   pop;
  logic                   sat_flag_reg;

  // Admission reserves a FIFO slot for the sample sitting in S1; a pop in
  // the same cycle is deliberately not credited, so S2 never meets a full FIFO.
  assign in_ready = ({1'b0, count_reg} + {{CW{1'b0}}, s1_valid_reg})
                    < (CW+1)'(FIFO_DEPTH);
  assign accept   = in_valid && in_ready;

  // Stage S1: capture the biased sum and the activation mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_sum_reg   <= '0;
      s1_mode_reg  <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_sum_reg  <= {in_result[RW-1], in_result} + {bias[RW-1], bias};
        s1_mode_reg <= mode;
      end
    end
  end

  // Stage S2: activation, round-half-up requantization, saturation.
  always_comb begin
    act = s1_sum_reg;
    case (s1_mode_reg)
      2'd1: if (s1_sum_reg[SW-1]) act = '0;
      2'd2: if (s1_sum_reg[SW-1]) act = s1_sum_reg >>> LEAK_SHIFT;
      default: act = s1_sum_reg;
    endcase
    q_biased  = {act[SW-1], act} + RND;
    q_shifted = q_biased >>> SHIFT;
    sat_hi    = q_shifted > QMAX;
    sat_lo    = q_shifted < QMIN;
    if (sat_hi)
      q_out = QMAX[WIDTH-1:0];
    else if (sat_lo)
      q_out = QMIN[WIDTH-1:0];
    else
      q_out = q_shifted[WIDTH-1:0];
  end

  assign push = s1_valid_reg;
  assign pop  = out_valid && out_ready;

  // FIFO storage; head is read combinationally so a fresh write is visible
  // on the very next cycle.
  always_ff @(posedge clk) begin
    if (!reset && push)
      mem_reg[wr_ptr_reg] <= q_out;
  end

  // Occupancy update from push/pop.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Sticky saturation flag: a saturating write beats a clear on the same edge.
  always_ff @(posedge clk) begin
    if (reset)
      sat_flag_reg <= 1'b0;
    else if (s1_valid_reg && (sat_hi || sat_lo))
      sat_flag_reg <= 1'b1;
    else if (clear_sat)
      sat_flag_reg <= 1'b0;
  end

  assign out_valid  = (count_reg != '0);
  assign out_data   = out_valid ? mem_reg[rd_ptr_reg] : '0;
  assign fifo_count = count_reg;
  assign sat_flag   = sat_flag_reg;

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: directed scenarios plus random
// streams compared against an arithmetic reference model.
module tb_activation_unit;

  localparam int WIDTH      = 8;
  localparam int SHIFT      = 2;
  localparam int LEAK_SHIFT = 3;
  localparam int FIFO_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [2*WIDTH:0]  in_result;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [2*WIDTH:0]  bias;
  logic [1:0]               mode;
  logic                     clear_sat;
  logic signed [WIDTH-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     sat_flag;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  activation_unit #(
    .WIDTH(WIDTH), .SHIFT(SHIFT), .LEAK_SHIFT(LEAK_SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_result(in_result), .in_valid(in_valid),
    .in_ready(in_ready), .bias(bias), .mode(mode), .clear_sat(clear_sat),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Floor division for a positive divisor.
  function automatic int floor_div(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Reference: value the stage must emit for one sample.
  function automatic int model(input int r, input int b, input int m);
    int s, a, q;
    s = r + b;
    a = s;
    if (m == 1 && s < 0) a = 0;
    if (m == 2 && s < 0) a = floor_div(s, 2 ** LEAK_SHIFT);
    q = floor_div(a + ((2 ** SHIFT) / 2), 2 ** SHIFT);
    if (q > 2 ** (WIDTH-1) - 1) q = 2 ** (WIDTH-1) - 1;
    if (q < -(2 ** (WIDTH-1)))  q = -(2 ** (WIDTH-1));
    return q;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a sample; the model records it only if the DUT can take it.
  task automatic offer(input int r, input int b, input int m);
    in_result = 17'(r);
    bias      = 17'(b);
    mode      = 2'(m);
    in_valid  = 1'b1;
    if (in_ready) exp_q.push_back(model(r, b, m));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %0b expected 0", sat_flag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_relu_positive();
    int e;
    out_ready = 1'b0;
    offer(14, 2, 1);
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL relu_early_valid: got %0b expected 0", out_valid); end
    cycle();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
    $display("relu out=%0d expected=%0d", out_data, e);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL relu_valid: got %0b expected 1", out_valid); end
    checks++; if (out_data !== 8'(e) || e == 9999) begin errors++; $display("FAIL relu_data: got %0d expected %0d", out_data, e); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL relu_sat: got %0b expected 0", sat_flag); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL relu_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_modes();
    int e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
        $display("modes out=%0d expected=%0d", out_data, e);
        checks++; if (out_data !== 8'(e) || e == 9999) begin errors++; $display("FAIL modes_data: got %0d expected %0d", out_data, e); end
      end
      if (i < 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL modes_in_ready: got %0b expected 1", in_ready); end
        offer(-10, 0, i);
      end else begin
        in_valid = 1'b0;
      end
      cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL modes_missing: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    int e;
    out_ready = 1'b1;
    clear_sat = 1'b0;
    offer(1000, 0, 0);
    cycle();
    in_valid = 1'b0;
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_early: got %0b expected 0", sat_flag); end
    cycle();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
    $display("sat out=%0d expected=%0d", out_data, e);
    checks++; if (out_data !== 8'(e) || out_valid !== 1'b1) begin errors++; $display("FAIL sat_pos_data: got %0d expected %0d", out_data, e); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_set: got %0b expected 1", sat_flag); end
    offer(-1000, 0, 3);
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_gap_valid: got %0b expected 0", out_valid); end
    cycle();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
    $display("sat out=%0d expected=%0d", out_data, e);
    checks++; if (out_data !== 8'(e) || out_valid !== 1'b1) begin errors++; $display("FAIL sat_neg_data: got %0d expected %0d", out_data, e); end
    offer(2000, 0, 0);
    cycle();
    in_valid  = 1'b0;
    clear_sat = 1'b1;
    cycle();
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_priority: got %0b expected 1", sat_flag); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
    $display("sat out=%0d expected=%0d", out_data, e);
    checks++; if (out_data !== 8'(e) || out_valid !== 1'b1) begin errors++; $display("FAIL sat_third_data: got %0d expected %0d", out_data, e); end
    cycle();
    clear_sat = 1'b0;
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0b expected 0", sat_flag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int e;
    int acc;
    acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== (acc < FIFO_DEPTH)) begin errors++; $display("FAIL bp_in_ready_%0d: got %0b expected %0b", i, in_ready, acc < FIFO_DEPTH); end
      offer((i + 1) * 10, 0, 0);
      if (in_ready) acc++;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d expected 4", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %0b expected 0", in_ready); end
    checks++; if (exp_q.size() == 0 || out_data !== 8'(exp_q[0])) begin errors++; $display("FAIL bp_head: got %0d expected first sample", out_data); end
    cycle();
    checks++; if (exp_q.size() == 0 || out_data !== 8'(exp_q[0]) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head_held: got %0d expected first sample", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
      $display("bp out=%0d expected=%0d", out_data, e);
      checks++; if (out_data !== 8'(e) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_data_%0d: got %0d expected %0d", i, out_data, e); end
      cycle();
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %0b expected 1", in_ready); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_fifth_captured: got out_valid %0b expected 0", out_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int e;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(int'($urandom_range(4000)) - 2000, int'($urandom_range(200)) - 100, int'($urandom_range(3)));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL b2b_prefill: got %0d expected 3", fifo_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
        $display("b2b out=%0d expected=%0d", out_data, e);
        checks++; if (out_data !== 8'(e) || e == 9999) begin errors++; $display("FAIL b2b_data_%0d: got %0d expected %0d", i, out_data, e); end
      end
      if (i < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d: got %0b expected 1", i, in_ready); end
        offer(int'($urandom_range(4000)) - 2000, int'($urandom_range(200)) - 100, int'($urandom_range(3)));
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (i < 8) begin
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d: got %0d expected 2", i, fifo_count); end
      end
    end
    checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    int e;
    out_ready = 1'b0;
    offer(1000, 0, 0);
    cycle();
    offer(20, 0, 0);
    cycle();
    offer(30, 0, 0);
    cycle();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2 || sat_flag !== 1'b1) begin errors++; $display("FAIL mid_precondition: got count %0d sat %0b expected 2 and 1", fifo_count, sat_flag); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b expected 0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_fifo_count: got %0d expected 0", fifo_count); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL mid_sat_flag: got %0b expected 0", sat_flag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %0b expected 1", in_ready); end
    out_ready = 1'b1;
    cycle();
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: got out_valid %0b data %0d expected nothing", out_valid, out_data); end
    out_ready = 1'b0;
    offer(14, 2, 1);
    cycle();
    in_valid = 1'b0;
    cycle();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
    $display("mid out=%0d expected=%0d", out_data, e);
    checks++; if (out_data !== 8'(e) || out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_sample: got %0d expected %0d", out_data, e); end
    out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    reset     = 1'b1;
    in_result = '0;
    in_valid  = 1'b0;
    bias      = '0;
    mode      = 2'd0;
    clear_sat = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_relu_positive();
    test_modes();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
Name: activation_unit

Overview:
- Post-neuron stage. Consumes each signed dot-product result from `neuron` (`result`, qualified by `done && valid`).
- Per sample: adds a bias, applies a selectable activation (identity / ReLU / leaky ReLU), rounds and requantizes back to WIDTH bits with saturation.
- Buffers outputs in a small FIFO with a valid/ready handshake towards the next layer.
- `in_ready` lets the layer controller hold off `neuron.start` under backpressure.

Parameters:
- WIDTH, 8, operand width of `neuron`; output sample width.
- SHIFT, 2, requantization right-shift (0..2*WIDTH).
- LEAK_SHIFT, 3, leaky-ReLU negative slope = 2^-LEAK_SHIFT.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_result  in  2*WIDTH+1  signed neuron result.
- in_valid  in  1  sample present; driven from neuron `done && valid`.
- in_ready  out  1  stage can accept a sample this cycle.
- bias  in  2*WIDTH+1  signed bias; sampled with the input.
- mode  in  2  0 = identity, 1 = ReLU, 2 = leaky ReLU, 3 = identity; sampled with the input.
- clear_sat  in  1  clears `sat_flag`.
- out_data  out  WIDTH  signed activated sample at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts `out_data`.
- sat_flag  out  1  sticky: any sample saturated.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:

Reset (synchronous):
- Clears the S1 register, FIFO pointers and `sat_flag`.
- After the reset edge: `out_valid`=0, `out_data`=0, `fifo_count`=0, `sat_flag`=0, `in_ready`=1.
- Reset mid-operation discards the in-flight sample and all FIFO contents; nothing is emitted for them.

Accept:
- A sample is accepted on an edge where `in_valid && in_ready`.
- `in_valid` while `in_ready`=0 is ignored; the sample is not captured. The upstream controller must not start the neuron while `in_ready`=0.

Stage S1 (accept edge E0): registers `sum = in_result + bias`, sign-extended to 2*WIDTH+2 bits (no overflow possible), plus `mode` and an S1-valid bit.

Stage S2 (combinational from S1, written to FIFO at E0+1):
- Activation:
  - Identity: a = sum.
  - ReLU: a = (sum<0) ? 0 : sum.
  - Leaky ReLU: a = (sum<0) ? (sum >>> LEAK_SHIFT) : sum. Arithmetic shift, floor.
- Requantize: q = (a + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. This is round-half-up; compute in a width that cannot overflow.
- Saturate: q > 2^(WIDTH-1)-1 gives 2^(WIDTH-1)-1; q < -2^(WIDTH-1) gives -2^(WIDTH-1). Either case sets `sat_flag`.

Latency and timing:
- A sample accepted at E0 is visible with `out_valid`=1 after E0+1, if the FIFO was empty.
- Throughput: 1 sample/cycle.

Flow control:
- `in_ready` = (fifo_count + S1valid) < FIFO_DEPTH, computed from registered state only. The same-cycle pop is not credited, which is conservative.
- Because of this reservation, an S2 write can never hit a full FIFO.

FIFO:
- First-in first-out order is preserved.
- Pop on edge when `out_valid && out_ready`. `out_ready` while empty is ignored.
- Simultaneous push and pop: occupancy unchanged, both take effect, pointers wrap modulo FIFO_DEPTH.
- `out_data` is the head entry; it is held stable while `out_valid && !out_ready`.

`sat_flag`:
- Priority: reset > set-by-saturation > `clear_sat`. A saturating write on the same edge as `clear_sat` leaves the flag at 1.

Test Plan:
1. ReLU, positive sample.
   - Stimulus: WIDTH=8, SHIFT=2. Neuron weights {4,3}, inputs {2,2}, result=14; bias=2, mode=1.
   - Required: sum 16 → q=(16+2)>>>2=4; `out_data`=4, `out_valid` one cycle after accept, `sat_flag`=0.
2. Negative result through all three modes.
   - Stimulus: result=-10, bias=0, mode=0/1/2 in consecutive cycles.
   - Required outputs in order: -2 (identity: (-10+2)>>>2); 0 (ReLU); 0 (leaky: -10>>>3=-2, then (-2+2)>>>2). All accepted back-to-back with `in_ready` high.
3. Saturation.
   - Stimulus: result=1000, identity; then result=-1000, identity.
   - Required: first gives (1002)>>>2=250 → 127; second gives (-998)>>>2=-250 → -128. `sat_flag` set after the first write. Pulse `clear_sat` with no saturating sample → `sat_flag`=0.
4. Backpressure.
   - Stimulus: FIFO_DEPTH=4, `out_ready`=0, offer results 10, 20, 30, 40, 50 on consecutive cycles.
   - Required: the first 4 are accepted; `in_ready`=0 once fifo_count + S1valid = 4; the 5th is not captured. Raise `out_ready`: outputs 3, 5, 8, 10 in order (10, 20, 30, 40 after round-half-up at SHIFT=2). `in_ready` returns to 1 on the edge after the first pop.
5. Simultaneous push and pop.
   - Stimulus: FIFO at 3/4 entries, `out_ready`=1 held, stream 8 samples continuously.
   - Required: `fifo_count` steady, pointers wrap, no loss or reordering, `out_data` sequence matches the golden model.
6. Reset mid-stream.
   - Stimulus: assert `reset` for one cycle with S1 valid and 2 FIFO entries.
   - Required: next cycle `out_valid`=0, `fifo_count`=0, `sat_flag`=0, `in_ready`=1. No stale sample emitted afterwards; a new sample (result 14, bias 2, ReLU) still gives 4.
